bram_fifo: RTL and testbench

BRAM_FIFO -- requirements
Module: bram_fifo

---
 rtl/bram.sv | 28 ++
 rtl/bram_fifo.sv | 99 +++++++++
 tb/tb_bram_fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bram.sv
// Simple dual-port block RAM: one synchronous write port, one synchronous read port.
// Read data appears the cycle after i_re; memory contents are not reset.
module bram #(
   parameter int DATA_SZ = 16,
   parameter int ADDR_SZ = 8
) (
   input  logic               i_clk,
   input  logic               i_we,
   input  logic [ADDR_SZ-1:0] i_waddr,
   input  logic [DATA_SZ-1:0] i_wdata,
   input  logic               i_re,
   input  logic [ADDR_SZ-1:0] i_raddr,
   output logic [DATA_SZ-1:0] o_rdata
);
   logic [DATA_SZ-1:0] r_mem [0:(1<<ADDR_SZ)-1];
   logic [DATA_SZ-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/bram_fifo.sv
// Valid/ready FIFO over a BRAM with a registered head word; push-to-valid latency 2 cycles.
// Writes stall only when full (no pop-through-full); reads sustain 1 word per 2 cycles.
module bram_fifo #(
   parameter int DATA_SZ = 16,
   parameter int ADDR_SZ = 8,
   parameter int MEM_MAX = (1 << ADDR_SZ)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_wr_valid,
   output logic               o_wr_ready,
   input  logic [DATA_SZ-1:0] i_wr_data,
   output logic               o_rd_valid,
   input  logic               i_rd_ready,
   output logic [DATA_SZ-1:0] o_rd_data,
   output logic [ADDR_SZ:0]   o_count
);
   localparam logic [ADDR_SZ:0]   LP_MAX  = (ADDR_SZ+1)'(MEM_MAX);
   localparam logic [ADDR_SZ-1:0] LP_LAST = ADDR_SZ'(MEM_MAX - 1);

   logic [ADDR_SZ-1:0] r_wr_ptr;
   logic [ADDR_SZ-1:0] r_rd_ptr;
   logic [ADDR_SZ:0]   r_bram_cnt;
   logic               r_pending;
   logic               r_rd_valid;
   logic [DATA_SZ-1:0] r_rd_data;

   logic               w_push;
   logic               w_pop;
   logic               w_fetch;
   logic               w_we;
   logic               w_re;
   logic [ADDR_SZ:0]   w_count;
   logic [DATA_SZ-1:0] w_bram_rdata;

   function automatic logic [ADDR_SZ-1:0] next_ptr(input logic [ADDR_SZ-1:0] ptr);
      return (ptr == LP_LAST) ? '0 : ptr + 1'b1;
   endfunction

   // Words in BRAM, plus one in flight from the BRAM, plus one in the output register.
   assign w_count    = r_bram_cnt
                     + {{ADDR_SZ{1'b0}}, r_pending}
                     + {{ADDR_SZ{1'b0}}, r_rd_valid};
   assign o_count    = w_count;
   assign o_wr_ready = (w_count < LP_MAX);
   assign o_rd_valid = r_rd_valid;
   assign o_rd_data  = r_rd_data;

   assign w_push  = i_wr_valid && o_wr_ready;
   assign w_pop   = r_rd_valid && i_rd_ready;
   // Pre-push count keeps the read address away from this cycle's write address.
   assign w_fetch = (r_bram_cnt != '0) && !r_pending && (!r_rd_valid || w_pop);

   assign w_we = w_push  && i_rst_n;
   assign w_re = w_fetch && i_rst_n;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_bram_cnt <= '0;
         r_pending  <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
         end
         if (w_fetch) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         case ({w_push, w_fetch})
            2'b10:   r_bram_cnt <= r_bram_cnt + 1'b1;
            2'b01:   r_bram_cnt <= r_bram_cnt - 1'b1;
            default: r_bram_cnt <= r_bram_cnt;
         endcase
         r_pending <= w_fetch;
         if (r_pending) begin
            r_rd_data  <= w_bram_rdata;
            r_rd_valid <= 1'b1;
         end else if (w_pop) begin
            r_rd_valid <= 1'b0;
         end
      end
   end

   bram #(
      .DATA_SZ (DATA_SZ),
      .ADDR_SZ (ADDR_SZ)
   ) u_bram (
      .i_clk   (i_clk),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (i_wr_data),
      .i_re    (w_re),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_bram_rdata)
   );
endmodule

// File: tb/tb_bram_fifo.sv
// Bench for bram_fifo: directed scenarios plus random traffic against a queue model.
module tb_bram_fifo;
   localparam int DW  = 16;
   localparam int AW  = 8;
   localparam int MAX = 256;

   logic          clk;
   logic          rst_n;
   logic          wr_valid;
   logic          wr_ready;
   logic [DW-1:0] wr_data;
   logic          rd_valid;
   logic          rd_ready;
   logic [DW-1:0] rd_data;
   logic [AW:0]   count;

   logic [DW-1:0] q[$];
   int            n_checks;
   int            n_fail;
   int            stall;
   int            pops;

   bram_fifo #(.DATA_SZ(DW), .ADDR_SZ(AW), .MEM_MAX(MAX)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_wr_valid (wr_valid),
      .o_wr_ready (wr_ready),
      .i_wr_data  (wr_data),
      .o_rd_valid (rd_valid),
      .i_rd_ready (rd_ready),
      .o_rd_data  (rd_data),
      .o_count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Apply inputs, check at the falling edge against the model, then let the edge happen.
   task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic rr);
      logic exp_rdy;
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
      @(negedge clk);
      exp_rdy = (q.size() < MAX);
      chk("count", count, q.size());
      chk("wr_ready", wr_ready, exp_rdy);
      if (q.size() == 0) begin
         chk("valid_when_empty", rd_valid, 0);
         stall = 0;
      end else begin
         stall = rd_valid ? 0 : stall + 1;
         chk("head_latency", (stall <= 2), 1);
      end
      if (rd_valid && rr && q.size() > 0) begin
         chk("rd_data", rd_data, q[0]);
         void'(q.pop_front());
         pops++;
      end
      if (wv && exp_rdy) q.push_back(wd);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 1500 && q.size() > 0; i++) cycle(1'b0, '0, 1'b1);
      chk("drain_empty", count, 0);
   endtask

   initial begin
      int k;
      int p0;
      n_checks = 0;
      n_fail   = 0;
      stall    = 0;
      pops     = 0;
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      wr_data  = '0;
      rd_ready = 1'b0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_ready", wr_ready, 1);
      chk("rst_valid", rd_valid, 0);
      chk("rst_data", rd_data, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single word: valid exactly two edges after the push.
      cycle(1'b1, 16'hA5A5, 1'b0);
      chk("single_lat1", rd_valid, 0);
      cycle(1'b0, '0, 1'b0);
      chk("single_lat2", rd_valid, 0);
      cycle(1'b0, '0, 1'b0);
      chk("single_valid", rd_valid, 1);
      chk("single_data", rd_data, 16'hA5A5);
      cycle(1'b0, '0, 1'b1);
      chk("single_empty", count, 0);

      // Fill to capacity, try one extra push, then drain in order.
      for (int i = 0; i < MAX; i++) cycle(1'b1, DW'(i), 1'b0);
      chk("full_ready", wr_ready, 0);
      chk("full_count", count, MAX);
      cycle(1'b1, 16'd999, 1'b0);
      chk("full_ignored", count, MAX);
      drain();

      // Cross the 255->0 address wrap.
      for (int i = 0; i < 200; i++) cycle(1'b1, DW'(2000 + i), 1'b0);
      drain();
      k = 0;
      for (int i = 0; i < 1000 && k < 100; i++) begin
         if (q.size() < MAX) begin
            cycle(1'b1, DW'(1000 + k), 1'b1);
            k++;
         end else begin
            cycle(1'b0, '0, 1'b1);
         end
      end
      chk("wrap_pushed", k, 100);
      drain();

      // Continuous push and pop: read side runs at half rate.
      k  = 0;
      p0 = pops;
      for (int i = 0; i < 500; i++) begin
         if (q.size() < MAX) begin
            cycle(1'b1, DW'(k), 1'b1);
            k++;
         end else begin
            cycle(1'b1, DW'(k), 1'b1);
         end
      end
      chk("read_rate", (pops - p0 >= 245) && (pops - p0 <= 250), 1);
      drain();

      // Head word held under backpressure while pushes continue.
      for (int i = 0; i < 5; i++) cycle(1'b1, DW'(16'h5000 + i), 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, DW'(16'h6000 + i), 1'b0);
         chk("bp_valid", rd_valid, 1);
         chk("bp_hold", rd_data, q[0]);
      end
      chk("bp_count", count, 15);
      drain();

      // Reset with 50 words held and a fetch in flight.
      for (int i = 0; i < 51; i++) cycle(1'b1, DW'(16'h7000 + i), 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
      cycle(1'b0, '0, 1'b1);
      chk("pre_rst_count", count, 50);
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_valid", rd_valid, 0);
      chk("mid_rst_ready", wr_ready, 1);
      q.delete();
      stall = 0;
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle(1'b1, 16'h1234, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
      chk("post_rst_valid", rd_valid, 1);
      chk("post_rst_first", rd_data, 16'h1234);
      drain();

      // Random traffic: a write-heavy phase to reach full, then a balanced phase.
      for (int i = 0; i < 1200; i++)
         cycle(($urandom_range(0, 7) != 0), DW'($urandom), ($urandom_range(0, 3) == 0));
      for (int i = 0; i < 1500; i++)
         cycle(($urandom_range(0, 1) != 0), DW'($urandom), ($urandom_range(0, 2) != 0));
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
